// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: pixel-rate divider, h/v counters and registered bright/hsync/vsync.
// Run/stop requests only take effect at frame boundaries, so frames are never truncated.
module vga_timing_ctrl #(
    parameter int CLK_DIV     = 2,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_ACT       = 640,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 29,
    parameter int V_ACT       = 480,
    parameter int SYNC_ACTIVE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       bright,
    output logic       hsync,
    output logic       vsync,
    output logic       pix_tick,
    output logic       frame_start,
    output logic       busy
);

    localparam int H_TOTAL = H_FP + H_SYNC + H_BP + H_ACT;
    localparam int V_TOTAL = V_FP + V_SYNC + V_BP + V_ACT;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_SYNC_LO = 10'(H_FP);
    localparam logic [9:0] H_SYNC_HI = 10'(H_FP + H_SYNC - 1);
    localparam logic [9:0] H_ACT_LO  = 10'(H_FP + H_SYNC + H_BP);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_SYNC_LO = 10'(V_FP);
    localparam logic [9:0] V_SYNC_HI = 10'(V_FP + V_SYNC - 1);
    localparam logic [9:0] V_ACT_LO  = 10'(V_FP + V_SYNC + V_BP);

    localparam logic SYNC_ON = (SYNC_ACTIVE != 0);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [9:0]       h_nxt;
    logic [9:0]       v_nxt;
    logic             h_wrap;
    logic             frame_end;
    logic             frame_start_nxt;
    logic             bright_nxt;
    logic             hsync_nxt;
    logic             vsync_nxt;

    function automatic logic in_range(input logic [9:0] val,
                                      input logic [9:0] lo,
                                      input logic [9:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

    assign busy     = (state != IDLE);
    assign pix_tick = (state != IDLE) && (div_cnt == DIV_LAST);
    assign h_wrap   = (h_count == H_LAST);
    assign frame_end = pix_tick && h_wrap && (v_count == V_LAST);

    always_comb begin
        state_nxt       = state;
        div_nxt         = div_cnt;
        h_nxt           = h_count;
        v_nxt           = v_count;
        frame_start_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt       = RUN;
                    frame_start_nxt = 1'b1;
                end
            end
            RUN: begin
                // A wrap while running always opens a new frame, even if a stop was just requested.
                if (frame_end) frame_start_nxt = 1'b1;
                if (!en) state_nxt = STOPPING;
            end
            STOPPING: begin
                if (en) state_nxt = RUN;
                else if (frame_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (state == IDLE) begin
            div_nxt = '0;
            h_nxt   = '0;
            v_nxt   = '0;
        end else begin
            div_nxt = pix_tick ? '0 : div_cnt + 1'b1;
            if (pix_tick) begin
                h_nxt = h_wrap ? 10'd0 : h_count + 10'd1;
                if (h_wrap) v_nxt = (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
            end
        end

        // Decoded from next-state counts so the registered flags line up with the counters.
        bright_nxt = (state_nxt != IDLE) && in_range(h_nxt, H_ACT_LO, H_LAST)
                     && in_range(v_nxt, V_ACT_LO, V_LAST);
        hsync_nxt  = ((state_nxt != IDLE) && in_range(h_nxt, H_SYNC_LO, H_SYNC_HI))
                     ? SYNC_ON : ~SYNC_ON;
        vsync_nxt  = ((state_nxt != IDLE) && in_range(v_nxt, V_SYNC_LO, V_SYNC_HI))
                     ? SYNC_ON : ~SYNC_ON;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            div_cnt     <= '0;
            h_count     <= '0;
            v_count     <= '0;
            bright      <= 1'b0;
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            div_cnt     <= div_nxt;
            h_count     <= h_nxt;
            v_count     <= v_nxt;
            bright      <= bright_nxt;
            hsync       <= hsync_nxt;
            vsync       <= vsync_nxt;
            frame_start <= frame_start_nxt;
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a reduced raster at CLK_DIV=2 and the full 640x480 raster at CLK_DIV=1,
// both scored every clock against a pixel-index reference model.
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       s_rstn, s_en, f_rstn, f_en;
    logic [9:0] s_h, s_v, f_h, f_v;
    logic       s_br, s_hs, s_vs, s_tk, s_fs, s_busy;
    logic       f_br, f_hs, f_vs, f_tk, f_fs, f_busy;

    vga_timing_ctrl #(
        .CLK_DIV(2), .H_FP(2), .H_SYNC(3), .H_BP(2), .H_ACT(8),
        .V_FP(1), .V_SYNC(2), .V_BP(1), .V_ACT(4), .SYNC_ACTIVE(0)
    ) u_small (
        .clk(clk), .rst_n(s_rstn), .en(s_en), .h_count(s_h), .v_count(s_v),
        .bright(s_br), .hsync(s_hs), .vsync(s_vs), .pix_tick(s_tk),
        .frame_start(s_fs), .busy(s_busy)
    );

    vga_timing_ctrl #(
        .CLK_DIV(1)
    ) u_full (
        .clk(clk), .rst_n(f_rstn), .en(f_en), .h_count(f_h), .v_count(f_v),
        .bright(f_br), .hsync(f_hs), .vsync(f_vs), .pix_tick(f_tk),
        .frame_start(f_fs), .busy(f_busy)
    );

    typedef struct packed {
        int div; int ht; int vt;
        int hs0; int hs1; int ha0;
        int vs0; int vs1; int va0;
    } cfg_t;

    // st: 0 idle, 1 run, 2 stopping; p is the pixel index within the frame
    typedef struct packed {
        int   st;
        int   dv;
        int   p;
        logic fs;
    } mst_t;

    localparam cfg_t CS = '{div: 2, ht: 15, vt: 8, hs0: 2, hs1: 4, ha0: 7,
                            vs0: 1, vs1: 2, va0: 4};
    localparam cfg_t CF = '{div: 1, ht: 800, vt: 521, hs0: 16, hs1: 111, ha0: 160,
                            vs0: 10, vs1: 11, va0: 41};

    mst_t        ms = '0;
    mst_t        mf = '0;
    logic [25:0] q_s[$];
    logic [25:0] q_f[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          fs_cnt = 0;
    int          last_fs = -1;
    bit          fs_meas = 1'b0;
    int          last_wrap = -1;
    logic [9:0]  prev_fh = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic mst_t mstep(cfg_t c, mst_t m, logic en_i, logic rn_i);
        mst_t n;
        logic tick, last;
        n = '0;
        if (!rn_i) return n;
        n    = m;
        n.fs = 1'b0;
        tick = (m.st != 0) && (m.dv == c.div - 1);
        last = tick && (m.p == c.ht * c.vt - 1);
        if (m.st == 0) begin
            if (en_i) begin
                n.st = 1;
                n.fs = 1'b1;
            end
        end else begin
            n.dv = tick ? 0 : m.dv + 1;
            if (tick) n.p = (m.p + 1) % (c.ht * c.vt);
            if (m.st == 1) begin
                if (last) n.fs = 1'b1;
                if (!en_i) n.st = 2;
            end else if (en_i) begin
                n.st = 1;
            end else if (last) begin
                n.st = 0;
            end
        end
        return n;
    endfunction

    function automatic logic [25:0] expv(cfg_t c, mst_t m);
        int   h, v;
        logic on, tk, br, hs, vs;
        h  = m.p % c.ht;
        v  = m.p / c.ht;
        on = (m.st != 0);
        tk = on && (m.dv == c.div - 1);
        br = on && (h >= c.ha0) && (v >= c.va0);
        hs = !(on && (h >= c.hs0) && (h <= c.hs1));
        vs = !(on && (v >= c.vs0) && (v <= c.vs1));
        return {on, m.fs, tk, vs, hs, br, 10'(v), 10'(h)};
    endfunction

    task automatic step();
        mst_t        ns, nf;
        logic [25:0] os, of_;
        ns = mstep(CS, ms, s_en, s_rstn);
        nf = mstep(CF, mf, f_en, f_rstn);
        q_s.push_back(expv(CS, ns));
        q_f.push_back(expv(CF, nf));
        ms = ns;
        mf = nf;
        @(posedge clk);
        #1;
        cyc++;
        os  = {s_busy, s_fs, s_tk, s_vs, s_hs, s_br, s_v, s_h};
        of_ = {f_busy, f_fs, f_tk, f_vs, f_hs, f_br, f_v, f_h};
        chk("small_out", 32'(os), 32'(q_s.pop_front()));
        chk("full_out", 32'(of_), 32'(q_f.pop_front()));
        if (s_fs) begin
            fs_cnt++;
            if (fs_meas) begin
                if (last_fs >= 0) chk("fs_gap", 32'(cyc - last_fs), 32'd240);
                last_fs = cyc;
            end
        end
        if (f_h == 10'd0 && prev_fh == 10'd799) begin
            if (last_wrap >= 0) chk("line_len", 32'(cyc - last_wrap), 32'd800);
            last_wrap = cyc;
        end
        prev_fh = f_h;
    endtask

    task automatic run_to_small(input int h, input int v, output bit found);
        found = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (s_h == 10'(h) && s_v == 10'(v)) begin
                found = 1'b1;
                break;
            end
            step();
        end
    endtask

    initial begin
        bit found;
        s_rstn = 1'b0; f_rstn = 1'b0; s_en = 1'b0; f_en = 1'b0;
        repeat (5) step();
        chk("rst_hv", 32'({s_v, s_h}), 32'd0);
        chk("rst_sync", 32'({s_hs, s_vs, f_hs, f_vs}), 32'hf);
        s_rstn = 1'b1; f_rstn = 1'b1;
        repeat (100) step();
        chk("idle_busy", 32'({s_busy, f_busy, s_tk, f_tk}), 32'd0);

        // Start: frame_start on the first running cycle, then once per 240-clk frame
        s_en = 1'b1;
        step();
        chk("first_fs", 32'(s_fs), 32'd1);
        fs_cnt = 0; fs_meas = 1'b1; last_fs = cyc;
        repeat (2 * 240 + 4) step();
        fs_meas = 1'b0;
        chk("fs_per_frame", 32'(fs_cnt), 32'd2);

        // Stop mid-frame: finishes the frame, then idles with no frame_start
        run_to_small(5, 3, found);
        chk("reach_stop_pt", 32'(found), 32'd1);
        s_en = 1'b0; fs_cnt = 0; found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (!s_busy) begin
                found = 1'b1;
                break;
            end
        end
        chk("stop_idle", 32'(found), 32'd1);
        chk("stop_fs", 32'(fs_cnt), 32'd0);
        chk("stop_hv", 32'({s_v, s_h}), 32'd0);
        repeat (10) step();

        // Brief stop request within a frame: no disturbance, next frame_start at natural wrap
        s_en = 1'b1;
        step();
        run_to_small(3, 2, found);
        chk("reach_pause_pt", 32'(found), 32'd1);
        s_en = 1'b0;
        repeat (6) step();
        s_en = 1'b1; found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (s_fs) begin
                found = 1'b1;
                break;
            end
        end
        chk("resume_fs_seen", 32'(found), 32'd1);
        chk("resume_fs_hv", 32'({s_v, s_h}), 32'd0);

        // Mid-frame reset with en held high
        run_to_small(10, 5, found);
        chk("reach_rst_pt", 32'(found), 32'd1);
        s_rstn = 1'b0;
        step();
        chk("mid_rst_hv", 32'({s_v, s_h}), 32'd0);
        chk("mid_rst_busy", 32'(s_busy), 32'd0);
        s_rstn = 1'b1;
        step();
        chk("restart_fs", 32'(s_fs), 32'd1);
        chk("restart_h", 32'(s_h), 32'd0);
        repeat (7) step();
        s_en = 1'b0;

        // Full raster, one pixel per clk: 800-clk lines, vsync window and first bright line
        f_en = 1'b1; last_wrap = -1;
        repeat (42 * 800 + 20) step();
        chk("full_v_reached", 32'(f_v >= 10'd42), 32'd1);
        f_rstn = 1'b0;
        step();
        chk("full_rst_hv", 32'({f_v, f_h}), 32'd0);
        f_rstn = 1'b1;
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
